pipe_hazard_ctrl: RTL

- Central sequencer for the 5-stage pipeline.
- Drives per-latch enables and flushes for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable.
- Detects load-use hazards, cache-wait stalls, taken branches/jumps and halt drain.
- Owns the LL/SC link register used by the MEM stage.
- Reports the pipeline condition as a pipe_stall_t status.

---
 rtl/pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall sequencer with LL/SC link register.
// Optional perf counters: define PIPE_PERF_CNT_EN.
package pipe_hazard_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [2:0] {
    NO_STALL   = 3'd0,
    IFID_STALL = 3'd1,
    IDEX_STALL = 3'd2,
    FULL_STALL = 3'd3
  } pipe_stall_t;
endpackage

module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int LINK_ADDR_W = 32,
  parameter int CNT_W       = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  regbits_t               ifid_rs,
  input  regbits_t               ifid_rt,
  input  regbits_t               idex_rt,
  input  logic                   idex_DataRead,
  input  logic                   exmem_dmemREN,
  input  logic                   exmem_dmemWEN,
  input  logic                   exmem_LinkedLoad,
  input  logic                   exmem_StoreConditional,
  input  logic [LINK_ADDR_W-1:0] exmem_addr,
  input  logic                   snoop_inv,
  input  logic [LINK_ADDR_W-1:0] snoop_addr,
  input  logic                   branch_taken,
  input  logic                   memwb_Halt,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   dmemWEN_eff,
  output logic                   sc_success,
  output logic                   link_valid,
  output logic                   halt,
  output logic [2:0]             stall_status,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_count,
  output logic [CNT_W-1:0]       lu_count
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e                 state_q, state_d;
  logic                   link_valid_q, link_valid_d;
  logic [LINK_ADDR_W-1:0] link_addr_q, link_addr_d;
  pipe_stall_t            status;
  logic                   run, snoop_hit, sc_ok;
  logic                   dwait, lu_haz, lu_ev, br_ev;

  assign run       = (state_q == RUN);
  assign snoop_hit = snoop_inv && (snoop_addr == link_addr_q);
  assign sc_ok     = link_valid_q && (exmem_addr == link_addr_q)
                     && !snoop_hit;

  assign sc_success  = exmem_StoreConditional && sc_ok;
  // A failing SC never reaches memory, so it cannot cause a dmem wait.
  assign dmemWEN_eff = run && exmem_dmemWEN
                       && (!exmem_StoreConditional || sc_ok);

  assign dwait  = (exmem_dmemREN || dmemWEN_eff) && !dhit;
  assign lu_haz = idex_DataRead && (idex_rt != '0)
                  && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  assign link_valid   = link_valid_q;
  assign halt         = !run;
  assign stall_status = status;

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    status     = FULL_STALL;
    lu_ev      = 1'b0;
    br_ev      = 1'b0;
    if (run) begin
      if (dwait) begin
        status = FULL_STALL;
      end else if (lu_haz) begin
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        idex_flush = 1'b1;
        status     = IDEX_STALL;
        lu_ev      = 1'b1;
      end else if (branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        status     = NO_STALL;
        br_ev      = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        status     = IFID_STALL;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        status   = NO_STALL;
      end
      if (memwb_Halt && memwb_en) state_d = HALTED;
    end
  end

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (snoop_hit) link_valid_d = 1'b0;
    if (run) begin
      if (exmem_StoreConditional && (!sc_ok || dhit))
        link_valid_d = 1'b0;
      if (exmem_dmemWEN && !exmem_StoreConditional && dhit
          && (exmem_addr == link_addr_q))
        link_valid_d = 1'b0;
      // LL is applied last so it wins over a same-cycle snoop.
      if (exmem_LinkedLoad && dhit) begin
        link_valid_d = 1'b1;
        link_addr_d  = exmem_addr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q, lu_q;
  logic             stall_ev;

  assign stall_ev = run && (status != NO_STALL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
    end else begin
      if (stall_ev && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (br_ev && (flush_q != '1))    flush_q <= flush_q + CNT_W'(1);
      if (lu_ev && (lu_q != '1))       lu_q    <= lu_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign lu_count     = lu_q;
`else
  logic unused_ev;
  assign unused_ev    = lu_ev ^ br_ev;
  assign stall_cycles = '0;
  assign flush_count  = '0;
  assign lu_count     = '0;
`endif

endmodule
